// File: rtl/bin_readout_if.sv
// Map-read and packed-byte stream signals between bin_readout and its neighbours.
// master = readout block, slave = map memory plus downstream byte consumer.
interface bin_readout_if #(
    parameter int ADDR_W = 16
);
    logic [ADDR_W-1:0] pixel_address;
    logic              bin_data;
    logic [7:0]        out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_sof;
    logic              out_eof;

    modport master (
        output pixel_address,
        input  bin_data,
        output out_data,
        output out_valid,
        output out_sof,
        output out_eof,
        input  out_ready
    );

    modport slave (
        input  pixel_address,
        output bin_data,
        input  out_data,
        input  out_valid,
        input  out_sof,
        input  out_eof,
        output out_ready
    );
endinterface

// File: rtl/bin_readout.sv
// Walks the binarization map one pixel per clock, packs 8 pixels LSB-first
// into a byte and streams the bytes out on a valid/ready link.
module bin_readout #(
    parameter int WIDTH  = 256,
    parameter int HEIGHT = 256,
    parameter int ADDR_W = 16
) (
    input  logic          bin_clk,
    input  logic          bin_rst,
    input  logic          rd_ctrl,
    bin_readout_if.master bus,
    output logic [1:0]    condition_led
);
    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(WIDTH * HEIGHT - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        idx_q, idx_d;
    logic [6:0]        shift_q, shift_d;
    logic [7:0]        data_q, data_d;
    logic              valid_q, valid_d;
    logic              sof_q, sof_d;
    logic              eof_q, eof_d;
    logic              done_q, done_d;
    logic              accept;
    logic              stall;

    always_comb begin
        accept  = valid_q && bus.out_ready;
        // Last bit of a byte can only be taken once the output register frees up.
        stall   = (idx_q == 3'd7) && valid_q && !bus.out_ready;
        state_d = state_q;
        addr_d  = addr_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = valid_q;
        sof_d   = sof_q;
        eof_d   = eof_q;
        done_d  = done_q;

        if (accept) valid_d = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (rd_ctrl) begin
                    state_d = SCAN;
                    addr_d  = '0;
                    idx_d   = '0;
                    done_d  = 1'b0;
                end
            end
            SCAN: begin
                if (!stall) begin
                    for (int i = 0; i < 7; i++) begin
                        if (idx_q == 3'(i)) shift_d[i] = bus.bin_data;
                    end
                    idx_d  = idx_q + 3'd1;
                    addr_d = addr_q + ADDR_W'(1);
                    if (idx_q == 3'd7) begin
                        data_d  = {bus.bin_data, shift_q};
                        valid_d = 1'b1;
                        sof_d   = (addr_q < ADDR_W'(8));
                        eof_d   = (addr_q == LAST_PIX);
                    end
                    if (addr_q == LAST_PIX) begin
                        state_d = DRAIN;
                        addr_d  = '0;
                    end
                end
            end
            DRAIN: begin
                // Only the eof byte can be pending here.
                if (accept) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge bin_clk) begin
        if (bin_rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            sof_q   <= 1'b0;
            eof_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            sof_q   <= sof_d;
            eof_q   <= eof_d;
            done_q  <= done_d;
        end
    end

    assign bus.pixel_address = addr_q;
    assign bus.out_data      = data_q;
    assign bus.out_valid     = valid_q;
    assign bus.out_sof       = sof_q;
    assign bus.out_eof       = eof_q;
    assign condition_led     = {done_q, (state_q == SCAN) || (state_q == DRAIN)};
endmodule

// File: tb/tb_bin_readout.sv
// Bench for bin_readout on a reduced 64x32 map: the map is a bit array, every
// accepted byte is checked against the packed map bits, output hold is watched.
module tb_bin_readout;
    localparam int WIDTH  = 64;
    localparam int HEIGHT = 32;
    localparam int ADDR_W = 16;
    localparam int N      = WIDTH * HEIGHT;
    localparam int NB     = N / 8;
    localparam int IW     = $clog2(N);

    logic       bin_clk = 1'b0;
    logic       bin_rst;
    logic       rd_ctrl;
    logic [1:0] condition_led;
    logic       map [N];

    int         n_cmp = 0;
    int         n_bad = 0;
    int         n_acc = 0;
    int         frame_start = 0;
    logic [7:0] last_data = 8'h00;

    bin_readout_if #(.ADDR_W(ADDR_W)) bus();

    bin_readout #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .ADDR_W(ADDR_W)) dut (
        .bin_clk       (bin_clk),
        .bin_rst       (bin_rst),
        .rd_ctrl       (rd_ctrl),
        .bus           (bus),
        .condition_led (condition_led)
    );

    always #5 bin_clk = ~bin_clk;

    assign bus.bin_data = (int'(bus.pixel_address) < N) ? map[bus.pixel_address[IW-1:0]] : 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Byte b of a frame is pixels 8b..8b+7, pixel 8b in bit 0.
    function automatic logic [7:0] exp_byte(input int b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = map[8 * b + i];
        return r;
    endfunction

    // Monitor: samples at negedge, so a handshake seen here completes on the next posedge.
    logic       hold_p = 1'b0;
    logic [7:0] hold_d = 8'h00;
    logic       hold_s = 1'b0;
    logic       hold_e = 1'b0;
    always @(negedge bin_clk) begin
        int b;
        chk("addr_range", (int'(bus.pixel_address) < N), 1'b1);
        if (bin_rst) begin
            hold_p = 1'b0;
        end else if (hold_p) begin
            chk("hold_valid", bus.out_valid, 1'b1);
            chk("hold_data", bus.out_data, hold_d);
            chk("hold_sof", bus.out_sof, hold_s);
            chk("hold_eof", bus.out_eof, hold_e);
        end
        if (!bin_rst && bus.out_valid && bus.out_ready) begin
            b = n_acc - frame_start;
            chk("byte_in_frame", (b < NB), 1'b1);
            if (b < NB) chk("byte_data", bus.out_data, exp_byte(b));
            chk("byte_sof", bus.out_sof, (b == 0));
            chk("byte_eof", bus.out_eof, (b == NB - 1));
            last_data = bus.out_data;
            n_acc++;
        end
        hold_p = !bin_rst && bus.out_valid && !bus.out_ready;
        hold_d = bus.out_data;
        hold_s = bus.out_sof;
        hold_e = bus.out_eof;
    end

    task automatic tick();
        @(posedge bin_clk);
        #1;
    endtask

    task automatic fill_map(input int kind);
        for (int k = 0; k < N; k++) begin
            case (kind)
                0:       map[k] = 1'b0;
                1:       map[k] = (k % 8 == 0);
                2:       map[k] = (k == N - 1);
                default: map[k] = 1'($urandom_range(0, 1));
            endcase
        end
    endtask

    // mode 0: ready high; 1: random ready; 2: 20-cycle stall while byte 2 is presented;
    // 3: reset at pixel 1000 (abort); 4: stray rd_ctrl pulse mid-scan.
    // Cycle c counts posedges after rd_ctrl is raised; c=1 is the SCAN-entry edge.
    task automatic run_frame(input int mode, output int done_cyc, output int first_v);
        int stall_left;
        bit stalled;
        stall_left  = 0;
        stalled     = 1'b0;
        done_cyc    = -1;
        first_v     = -1;
        frame_start = n_acc;
        bus.out_ready = 1'b1;
        rd_ctrl     = 1'b1;
        for (int c = 1; c <= 4 * N + 200; c++) begin
            tick();
            rd_ctrl = (mode == 4 && c == 500);
            if (first_v < 0 && bus.out_valid) first_v = c;
            if (condition_led == 2'b10) begin
                done_cyc = c;
                break;
            end
            if (mode == 3 && int'(bus.pixel_address) == 1000) begin
                bin_rst = 1'b1;
                tick();
                bin_rst = 1'b0;
                chk("rst_mid_addr", bus.pixel_address, 16'h0000);
                chk("rst_mid_valid", bus.out_valid, 1'b0);
                chk("rst_mid_data", bus.out_data, 8'h00);
                chk("rst_mid_sof", bus.out_sof, 1'b0);
                chk("rst_mid_eof", bus.out_eof, 1'b0);
                chk("rst_mid_led", condition_led, 2'b00);
                done_cyc = -2;
                break;
            end
            case (mode)
                1: bus.out_ready = 1'($urandom_range(0, 1));
                2: begin
                    if (!stalled && n_acc - frame_start == 2 && bus.out_valid) begin
                        stalled    = 1'b1;
                        stall_left = 20;
                    end
                    if (stall_left > 0) begin
                        bus.out_ready = 1'b0;
                        stall_left--;
                        if (stall_left == 5) begin
                            chk("stall_addr", bus.pixel_address, 16'd31);
                            chk("stall_valid", bus.out_valid, 1'b1);
                            chk("stall_data", bus.out_data, exp_byte(2));
                        end
                    end else begin
                        bus.out_ready = 1'b1;
                    end
                end
                default: bus.out_ready = 1'b1;
            endcase
        end
        rd_ctrl = 1'b0;
        bus.out_ready = 1'b1;
    endtask

    task automatic check_done(input string tag);
        chk({tag, "_bytes"}, (n_acc - frame_start), NB);
        chk({tag, "_led"}, condition_led, 2'b10);
        chk({tag, "_addr"}, bus.pixel_address, 16'h0000);
        chk({tag, "_valid"}, bus.out_valid, 1'b0);
    endtask

    initial begin
        int dc;
        int fv;
        bin_rst = 1'b1;
        rd_ctrl = 1'b0;
        bus.out_ready = 1'b1;
        fill_map(0);
        tick();
        tick();
        chk("rst_addr", bus.pixel_address, 16'h0000);
        chk("rst_valid", bus.out_valid, 1'b0);
        chk("rst_data", bus.out_data, 8'h00);
        chk("rst_sof", bus.out_sof, 1'b0);
        chk("rst_eof", bus.out_eof, 1'b0);
        chk("rst_led", condition_led, 2'b00);
        bin_rst = 1'b0;
        tick();

        // all-zero map, latency and frame length
        run_frame(0, dc, fv);
        chk("zero_first_valid", fv, 9);
        chk("zero_done_cyc", dc, N + 2);
        check_done("zero");
        chk("zero_last", last_data, 8'h00);

        fill_map(1);
        run_frame(0, dc, fv);
        chk("lsb_done_cyc", dc, N + 2);
        check_done("lsb");
        chk("lsb_last", last_data, 8'h01);

        fill_map(2);
        run_frame(0, dc, fv);
        check_done("lastpix");
        chk("lastpix_last", last_data, 8'h80);

        fill_map(3);
        run_frame(2, dc, fv);
        chk("stall_done", (dc > 0), 1'b1);
        check_done("stall");

        for (int r = 0; r < 2; r++) begin
            fill_map(3);
            run_frame(1, dc, fv);
            chk("rand_done", (dc > 0), 1'b1);
            check_done("rand");
        end

        // abort by reset, then a clean frame
        fill_map(3);
        run_frame(3, dc, fv);
        chk("abort_seen", dc, -2);
        repeat (5) tick();
        chk("abort_idle_led", condition_led, 2'b00);
        chk("abort_idle_valid", bus.out_valid, 1'b0);
        run_frame(0, dc, fv);
        chk("restart_done_cyc", dc, N + 2);
        check_done("restart");

        // stray start pulse in SCAN is ignored
        fill_map(3);
        run_frame(4, dc, fv);
        chk("midpulse_done_cyc", dc, N + 2);
        check_done("midpulse");

        // level held in DONE restarts once; released mid-scan, frame ends in DONE
        fill_map(3);
        frame_start = n_acc;
        rd_ctrl = 1'b1;
        tick();
        chk("hold_restart_led", condition_led, 2'b01);
        repeat (100) tick();
        rd_ctrl = 1'b0;
        dc = -1;
        for (int c = 0; c < 2 * N; c++) begin
            tick();
            if (condition_led == 2'b10) begin
                dc = c;
                break;
            end
        end
        chk("hold_done", (dc >= 0), 1'b1);
        repeat (50) tick();
        check_done("hold");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
